// File: rtl/command_dispatch_and_collect_pkg.sv
//=============================================================================
// command_dispatch_and_collect_pkg: shared widths and FSM state encodings
// Revision: 1.0
//=============================================================================
`default_nettype none

package command_dispatch_and_collect_pkg;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_RESP     = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/command_dispatch_and_collect_rsp_mux.sv
//=============================================================================
// cmd_rsp_mux: selects one responder's reply slice from the flattened buses
// Revision: 1.0
//=============================================================================
`default_nettype none

module cmd_rsp_mux
   import command_dispatch_and_collect_pkg::*;
#(
   parameter int NUM_MOD = 4,
   parameter int MOD_W   = 2
) (
   input  logic [MOD_W-1:0]          sel,
   input  logic [NUM_MOD-1:0]        rsp_wr,
   input  logic [NUM_MOD*ADDR_W-1:0] rsp_addr,
   input  logic [NUM_MOD-1:0]        rsp_addr_fixed,
   input  logic [NUM_MOD*DATA_W-1:0] rsp_rdata,
   output logic                      sel_wr,
   output logic [ADDR_W-1:0]         sel_addr,
   output logic                      sel_addr_fixed,
   output logic [DATA_W-1:0]         sel_rdata
);

   // An out-of-range select yields an all-zero (never valid) reply.
   always_comb begin
      sel_wr         = 1'b0;
      sel_addr       = '0;
      sel_addr_fixed = 1'b0;
      sel_rdata      = '0;
      for (int k = 0; k < NUM_MOD; k++) begin
         if (sel == MOD_W'(k)) begin
            sel_wr         = rsp_wr[k];
            sel_addr       = rsp_addr[k*ADDR_W +: ADDR_W];
            sel_addr_fixed = rsp_addr_fixed[k];
            sel_rdata      = rsp_rdata[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/command_dispatch_and_collect.sv
//=============================================================================
// command_dispatch_and_collect: config command initiator with read collection and timeout
// Revision: 1.0
//=============================================================================
`default_nettype none

module command_dispatch_and_collect
   import command_dispatch_and_collect_pkg::*;
#(
   parameter int NUM_MOD     = 4,
   parameter int MOD_W       = 2,
   parameter int TIMEOUT_CYC = 16,
   parameter int CNT_W       = 32
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_cmd_valid,
   output logic                      o_cmd_ready,
   input  logic                      i_cmd_rd,
   input  logic [MOD_W-1:0]          iv_cmd_mod,
   input  logic [ADDR_W-1:0]         iv_cmd_addr,
   input  logic                      i_cmd_addr_fixed,
   input  logic [DATA_W-1:0]         iv_cmd_wdata,
   output logic [NUM_MOD-1:0]        ov_wr,
   output logic [NUM_MOD-1:0]        ov_rd,
   output logic [ADDR_W-1:0]         ov_addr,
   output logic                      o_addr_fixed,
   output logic [DATA_W-1:0]         ov_wdata,
   input  logic [NUM_MOD-1:0]        iv_rsp_wr,
   input  logic [NUM_MOD*ADDR_W-1:0] iv_rsp_addr,
   input  logic [NUM_MOD-1:0]        iv_rsp_addr_fixed,
   input  logic [NUM_MOD*DATA_W-1:0] iv_rsp_rdata,
   output logic                      o_rsp_valid,
   output logic                      o_rsp_err,
   output logic [ADDR_W-1:0]         ov_rsp_addr,
   output logic                      o_rsp_addr_fixed,
   output logic [DATA_W-1:0]         ov_rsp_rdata,
   output logic [CNT_W-1:0]          ov_err_cnt
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

   state_t              state;
   logic                cmd_rd;
   logic [MOD_W-1:0]    cmd_mod;
   logic [ADDR_W-1:0]   cmd_addr;
   logic                cmd_addr_fixed;
   logic [TMR_W-1:0]    timer;

   logic                mod_ok;
   logic [NUM_MOD-1:0]  onehot;
   logic                sel_wr;
   logic [ADDR_W-1:0]   sel_addr;
   logic                sel_addr_fixed;
   logic [DATA_W-1:0]   sel_rdata;
   logic                rsp_match;
   logic [CNT_W-1:0]    err_cnt_inc;

   assign o_cmd_ready = (state == ST_IDLE);
   assign mod_ok      = ({1'b0, iv_cmd_mod} < (MOD_W+1)'(NUM_MOD));
   assign onehot      = NUM_MOD'(1) << iv_cmd_mod;
   assign rsp_match   = (sel_addr == cmd_addr) && (sel_addr_fixed == cmd_addr_fixed);
   assign err_cnt_inc = (ov_err_cnt == '1) ? ov_err_cnt : ov_err_cnt + 1'b1;

   cmd_rsp_mux #(
      .NUM_MOD (NUM_MOD),
      .MOD_W   (MOD_W)
   ) u_rsp_mux (
      .sel            (cmd_mod),
      .rsp_wr         (iv_rsp_wr),
      .rsp_addr       (iv_rsp_addr),
      .rsp_addr_fixed (iv_rsp_addr_fixed),
      .rsp_rdata      (iv_rsp_rdata),
      .sel_wr         (sel_wr),
      .sel_addr       (sel_addr),
      .sel_addr_fixed (sel_addr_fixed),
      .sel_rdata      (sel_rdata)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state            <= ST_IDLE;
         cmd_rd           <= 1'b0;
         cmd_mod          <= '0;
         cmd_addr         <= '0;
         cmd_addr_fixed   <= 1'b0;
         timer            <= '0;
         ov_wr            <= '0;
         ov_rd            <= '0;
         ov_addr          <= '0;
         o_addr_fixed     <= 1'b0;
         ov_wdata         <= '0;
         o_rsp_valid      <= 1'b0;
         o_rsp_err        <= 1'b0;
         ov_rsp_addr      <= '0;
         o_rsp_addr_fixed <= 1'b0;
         ov_rsp_rdata     <= '0;
         ov_err_cnt       <= '0;
      end else begin
         ov_wr            <= '0;
         ov_rd            <= '0;
         ov_addr          <= '0;
         o_addr_fixed     <= 1'b0;
         ov_wdata         <= '0;
         o_rsp_valid      <= 1'b0;
         o_rsp_err        <= 1'b0;
         ov_rsp_addr      <= '0;
         o_rsp_addr_fixed <= 1'b0;
         ov_rsp_rdata     <= '0;
         case (state)
            ST_IDLE: begin
               if (i_cmd_valid) begin
                  cmd_rd         <= i_cmd_rd;
                  cmd_mod        <= iv_cmd_mod;
                  cmd_addr       <= iv_cmd_addr;
                  cmd_addr_fixed <= i_cmd_addr_fixed;
                  if (mod_ok) begin
                     state        <= ST_ISSUE;
                     ov_addr      <= iv_cmd_addr;
                     o_addr_fixed <= i_cmd_addr_fixed;
                     ov_wdata     <= iv_cmd_wdata;
                     if (i_cmd_rd) ov_rd <= onehot;
                     else          ov_wr <= onehot;
                  end else if (i_cmd_rd) begin
                     // Unknown module: complete the read with an error straight away.
                     state            <= ST_RESP;
                     o_rsp_valid      <= 1'b1;
                     o_rsp_err        <= 1'b1;
                     ov_rsp_addr      <= iv_cmd_addr;
                     o_rsp_addr_fixed <= i_cmd_addr_fixed;
                     ov_err_cnt       <= err_cnt_inc;
                  end
               end
            end
            ST_ISSUE: begin
               timer <= '0;
               state <= cmd_rd ? ST_WAIT_RSP : ST_IDLE;
            end
            ST_WAIT_RSP: begin
               timer <= timer + 1'b1;
               // Deciding on the last-but-one count puts the timeout pulse
               // exactly TIMEOUT_CYC cycles after the read strobe.
               if (sel_wr || (timer == TMR_W'(TIMEOUT_CYC - 2))) begin
                  state            <= ST_RESP;
                  o_rsp_valid      <= 1'b1;
                  ov_rsp_addr      <= cmd_addr;
                  o_rsp_addr_fixed <= cmd_addr_fixed;
                  if (sel_wr && rsp_match) begin
                     ov_rsp_rdata <= sel_rdata;
                  end else begin
                     o_rsp_err  <= 1'b1;
                     ov_err_cnt <= err_cnt_inc;
                  end
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_command_dispatch_and_collect.sv
//=============================================================================
// tb_command_dispatch_and_collect: scoreboard bench for the command initiator
// Revision: 1.0
//=============================================================================
`default_nettype none

module tb_command_dispatch_and_collect;

   localparam int NUM_MOD = 4;
   localparam int MOD_W   = 3;
   localparam int TO_CYC  = 16;
   localparam int CNT_W   = 3;
   localparam int AW      = 19;
   localparam int DW      = 32;

   logic                   clk;
   logic                   rst_n;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic                   cmd_rd;
   logic [MOD_W-1:0]       cmd_mod;
   logic [AW-1:0]          cmd_addr;
   logic                   cmd_addr_fixed;
   logic [DW-1:0]          cmd_wdata;
   logic [NUM_MOD-1:0]     wr;
   logic [NUM_MOD-1:0]     rd;
   logic [AW-1:0]          addr;
   logic                   addr_fixed;
   logic [DW-1:0]          wdata;
   logic [NUM_MOD-1:0]     rsp_wr;
   logic [NUM_MOD*AW-1:0]  rsp_addr;
   logic [NUM_MOD-1:0]     rsp_addr_fixed;
   logic [NUM_MOD*DW-1:0]  rsp_rdata;
   logic                   rsp_valid;
   logic                   rsp_err;
   logic [AW-1:0]          rsp_addr_o;
   logic                   rsp_addr_fixed_o;
   logic [DW-1:0]          rsp_rdata_o;
   logic [CNT_W-1:0]       err_cnt;

   typedef struct {
      logic          err;
      logic [AW-1:0] addr;
      logic          fixed;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks   = 0;
   int   failures = 0;
   int   lat;

   command_dispatch_and_collect #(
      .NUM_MOD     (NUM_MOD),
      .MOD_W       (MOD_W),
      .TIMEOUT_CYC (TO_CYC),
      .CNT_W       (CNT_W)
   ) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_cmd_valid       (cmd_valid),
      .o_cmd_ready       (cmd_ready),
      .i_cmd_rd          (cmd_rd),
      .iv_cmd_mod        (cmd_mod),
      .iv_cmd_addr       (cmd_addr),
      .i_cmd_addr_fixed  (cmd_addr_fixed),
      .iv_cmd_wdata      (cmd_wdata),
      .ov_wr             (wr),
      .ov_rd             (rd),
      .ov_addr           (addr),
      .o_addr_fixed      (addr_fixed),
      .ov_wdata          (wdata),
      .iv_rsp_wr         (rsp_wr),
      .iv_rsp_addr       (rsp_addr),
      .iv_rsp_addr_fixed (rsp_addr_fixed),
      .iv_rsp_rdata      (rsp_rdata),
      .o_rsp_valid       (rsp_valid),
      .o_rsp_err         (rsp_err),
      .ov_rsp_addr       (rsp_addr_o),
      .o_rsp_addr_fixed  (rsp_addr_fixed_o),
      .ov_rsp_rdata      (rsp_rdata_o),
      .ov_err_cnt        (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Completion monitor: every pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(1), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("rsp_err",   64'(rsp_err),          64'(e.err));
            check("rsp_addr",  64'(rsp_addr_o),       64'(e.addr));
            check("rsp_fixed", 64'(rsp_addr_fixed_o), 64'(e.fixed));
            check("rsp_rdata", 64'(rsp_rdata_o),      64'(e.rdata));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic err, input logic [AW-1:0] a, input logic f, input logic [DW-1:0] d);
      exp_t x;
      x.err = err; x.addr = a; x.fixed = f; x.rdata = d;
      exp_q.push_back(x);
   endtask

   // Presents a command for one cycle; returns in the cycle after acceptance.
   task automatic send(input logic r, input logic [MOD_W-1:0] m, input logic [AW-1:0] a,
                       input logic f, input logic [DW-1:0] d);
      cmd_valid = 1'b1; cmd_rd = r; cmd_mod = m; cmd_addr = a; cmd_addr_fixed = f; cmd_wdata = d;
      tick();
      cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_mod = '0; cmd_addr = '0; cmd_addr_fixed = 1'b0; cmd_wdata = '0;
   endtask

   task automatic set_reply(input int k, input logic [AW-1:0] a, input logic f, input logic [DW-1:0] d);
      rsp_wr[k]              = 1'b1;
      rsp_addr[k*AW +: AW]   = a;
      rsp_addr_fixed[k]      = f;
      rsp_rdata[k*DW +: DW]  = d;
   endtask

   task automatic clr_reply();
      rsp_wr = '0; rsp_addr = '0; rsp_addr_fixed = '0; rsp_rdata = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_mod = '0; cmd_addr = '0; cmd_addr_fixed = 1'b0; cmd_wdata = '0;
      clr_reply();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      check("reset_ready",   64'(cmd_ready),  64'(1));
      check("reset_rd",      64'(rd),         64'(0));
      check("reset_wr",      64'(wr),         64'(0));
      check("reset_rsp_vld", 64'(rsp_valid),  64'(0));
      check("reset_err_cnt", 64'(err_cnt),    64'(0));

      // Read module 1 answered by a registered responder.
      push_exp(1'b0, 19'h0, 1'b1, 32'h0000_00A5);
      send(1'b1, 3'd1, 19'h0, 1'b1, 32'h0);
      check("rd1_strobe", 64'(rd), 64'(4'b0010));
      check("rd1_fixed",  64'(addr_fixed), 64'(1));
      check("rd1_busy",   64'(cmd_ready), 64'(0));
      tick();
      set_reply(1, 19'h0, 1'b1, 32'h0000_00A5);
      tick();
      clr_reply();
      check("rd1_valid_t3", 64'(rsp_valid), 64'(1));
      tick();
      check("rd1_ready", 64'(cmd_ready), 64'(1));

      // Posted write to module 2.
      send(1'b0, 3'd2, 19'h40, 1'b0, 32'hDEAD_BEEF);
      check("wr2_strobe", 64'(wr),    64'(4'b0100));
      check("wr2_no_rd",  64'(rd),    64'(0));
      check("wr2_addr",   64'(addr),  64'(19'h40));
      check("wr2_wdata",  64'(wdata), 64'(32'hDEAD_BEEF));
      tick();
      check("wr2_ready_t2", 64'(cmd_ready), 64'(1));
      check("wr2_strobe_off", 64'(wr), 64'(0));
      check("wr2_wdata_off",  64'(wdata), 64'(0));

      // Read module 0 with no reply: timeout.
      push_exp(1'b1, 19'h5, 1'b0, 32'h0);
      send(1'b1, 3'd0, 19'h5, 1'b0, 32'h0);
      check("to_strobe", 64'(rd), 64'(4'b0001));
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (rsp_valid) begin
            lat = i;
            break;
         end
      end
      check("to_latency", 64'(lat), 64'(TO_CYC));
      check("to_err_cnt", 64'(err_cnt), 64'(1));
      tick();

      // Reply arriving in the final wait cycle beats the timeout.
      push_exp(1'b0, 19'h7, 1'b0, 32'h1234_5678);
      send(1'b1, 3'd2, 19'h7, 1'b0, 32'h0);
      repeat (TO_CYC - 1) tick();
      set_reply(2, 19'h7, 1'b0, 32'h1234_5678);
      tick();
      clr_reply();
      check("late_valid", 64'(rsp_valid), 64'(1));
      check("late_err_cnt", 64'(err_cnt), 64'(1));
      tick();

      // Read module 3: a module-1 reply is ignored, then a mismatched module-3 reply errors.
      push_exp(1'b1, 19'h123, 1'b0, 32'h0);
      send(1'b1, 3'd3, 19'h123, 1'b0, 32'h0);
      check("rd3_strobe", 64'(rd), 64'(4'b1000));
      tick();
      set_reply(1, 19'h123, 1'b0, 32'h111);
      tick();
      clr_reply();
      check("rd3_other_ignored", 64'(rsp_valid), 64'(0));
      set_reply(3, 19'h124, 1'b0, 32'h333);
      tick();
      clr_reply();
      check("rd3_mismatch_valid", 64'(rsp_valid), 64'(1));
      check("rd3_err_cnt", 64'(err_cnt), 64'(2));
      tick();

      // Out-of-range module: read errors at T+1, write is dropped.
      push_exp(1'b1, 19'h55, 1'b1, 32'h0);
      send(1'b1, 3'd5, 19'h55, 1'b1, 32'h0);
      check("bad_rd_no_strobe", 64'(rd), 64'(0));
      check("bad_rd_valid",     64'(rsp_valid), 64'(1));
      check("bad_rd_err",       64'(rsp_err), 64'(1));
      check("bad_err_cnt",      64'(err_cnt), 64'(3));
      tick();
      send(1'b0, 3'd6, 19'h66, 1'b0, 32'hCAFE);
      check("bad_wr_no_strobe", 64'(wr), 64'(0));
      check("bad_wr_ready",     64'(cmd_ready), 64'(1));
      tick();

      // Drive the error counter into saturation.
      for (int n = 4; n <= 9; n++) begin
         push_exp(1'b1, 19'(n), 1'b0, 32'h0);
         send(1'b1, 3'd7, 19'(n), 1'b0, 32'h0);
         check("sat_err_cnt", 64'(err_cnt), 64'((n > 7) ? 7 : n));
         tick();
      end

      // Async reset while waiting for a reply aborts the read.
      send(1'b1, 3'd1, 19'h10, 1'b0, 32'h0);
      tick();
      rst_n = 1'b0;
      #2;
      check("rst_ready",   64'(cmd_ready), 64'(1));
      check("rst_rd",      64'(rd), 64'(0));
      check("rst_rsp_vld", 64'(rsp_valid), 64'(0));
      check("rst_err_cnt", 64'(err_cnt), 64'(0));
      tick();
      tick();
      rst_n = 1'b1;
      set_reply(1, 19'h10, 1'b0, 32'hBEEF);
      tick();
      clr_reply();
      repeat (3) tick();
      check("rst_no_pulse", 64'(rsp_valid), 64'(0));
      check("rst_ready_after", 64'(cmd_ready), 64'(1));
      check("exp_q_drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
